// File: rtl/dmem_responder.sv
// Data-memory responder: req/ack load/store port with configurable wait states.
// Define DMEM_RANGECHK_EN to flag latched addresses >= DEPTH as errors instead of aliasing them.
module dmem_responder #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int DEPTH       = 32,
    parameter int WAIT_STATES = 1
) (
    input  logic              MClock,
    input  logic              Resetn,
    input  logic              req,
    input  logic              w,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ack,
    output logic              busy,
    output logic              err,
    output logic [15:0]       access_count
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, ACK} state_t;

    state_t            state_reg, state_next;
    logic [3:0]        wait_reg, wait_next;
    logic              w_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic              err_reg;
    logic [15:0]       count_reg;
    logic [DATA_W-1:0] mem [DEPTH];

    logic [IDX_W-1:0]  index;
    logic              upper_nz;
    logic              oor;

    assign index = addr_reg[IDX_W-1:0];

    generate
        if (ADDR_W > IDX_W) begin : g_upper
            assign upper_nz = |addr_reg[ADDR_W-1:IDX_W];
        end else begin : g_no_upper
            assign upper_nz = 1'b0;
        end
    endgenerate

`ifdef DMEM_RANGECHK_EN
    assign oor = upper_nz;
`else
    // Upper address bits are discarded, so out-of-range addresses alias.
    logic upper_unused;
    assign upper_unused = upper_nz;
    assign oor = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        wait_next  = wait_reg;
        case (state_reg)
            IDLE: begin
                if (req) begin
                    wait_next  = WAIT_INIT;
                    state_next = (WAIT_INIT != 4'd0) ? WAIT : ACCESS;
                end
            end
            WAIT: begin
                wait_next = wait_reg - 4'd1;
                if (wait_reg <= 4'd1) begin
                    state_next = ACCESS;
                end
            end
            ACCESS:  state_next = ACK;
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge MClock or negedge Resetn) begin
        if (!Resetn) begin
            state_reg <= IDLE;
            wait_reg  <= '0;
            w_reg     <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
            err_reg   <= 1'b0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            wait_reg  <= wait_next;
            if (state_reg == IDLE && req) begin
                w_reg     <= w;
                addr_reg  <= addr;
                wdata_reg <= wdata;
            end
            if (state_reg == ACCESS) begin
                err_reg <= oor;
                if (!w_reg) begin
                    rdata_reg <= oor ? '0 : mem[index];
                end
            end
            if (state_reg == ACK) begin
                err_reg   <= 1'b0;
                count_reg <= count_reg + 16'd1;
            end
        end
    end

    // Array is deliberately unreset so its contents survive Resetn.
    always_ff @(posedge MClock) begin
        if (state_reg == ACCESS && w_reg && !oor) begin
            mem[index] <= wdata_reg;
        end
    end

    assign rdata        = rdata_reg;
    assign ack          = (state_reg == ACK);
    assign busy         = (state_reg != IDLE);
    assign err          = err_reg;
    assign access_count = count_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder against a behavioural memory model.
module tb_dmem_responder;

    localparam int WS    = 2;
    localparam int DEPTH = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        w = 1'b0;
    logic [15:0] addr = '0;
    logic [15:0] wdata = '0;
    logic [15:0] rdata;
    logic        ack;
    logic        busy;
    logic        err;
    logic [15:0] access_count;

    int checks = 0;
    int errors = 0;

    logic [15:0] ref_mem [DEPTH];
    logic [15:0] ref_rdata = '0;
    logic [15:0] ref_count = '0;

    always #5 clk = ~clk;

    dmem_responder #(
        .DATA_W(16),
        .ADDR_W(16),
        .DEPTH(DEPTH),
        .WAIT_STATES(WS)
    ) dut (
        .MClock(clk),
        .Resetn(rst_n),
        .req(req),
        .w(w),
        .addr(addr),
        .wdata(wdata),
        .rdata(rdata),
        .ack(ack),
        .busy(busy),
        .err(err),
        .access_count(access_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Entered and left at a falling edge with the DUT idle.
    task automatic txn(input logic tw, input logic [15:0] ta, input logic [15:0] td, input bit hold);
        logic        exp_err;
        int          idx;
        logic [15:0] prev_rdata;
        exp_err = 1'b0;
`ifdef DMEM_RANGECHK_EN
        exp_err = (int'(ta) >= DEPTH);
`endif
        idx = int'(ta) % DEPTH;
        prev_rdata = ref_rdata;
        if (!exp_err) begin
            if (tw) ref_mem[idx] = td;
            else    ref_rdata = ref_mem[idx];
        end else if (!tw) begin
            ref_rdata = '0;
        end

        req = 1'b1; w = tw; addr = ta; wdata = td;
        @(posedge clk);
        @(negedge clk);
        if (!hold) req = 1'b0;
        w = 1'($urandom); addr = 16'($urandom); wdata = 16'($urandom);

        for (int k = 0; k <= WS + 1; k++) begin
            if (k > 0) begin
                @(posedge clk);
                @(negedge clk);
            end
            check("busy_txn", 32'(busy), 32'(1));
            check("ack_txn", 32'(ack), 32'(k == WS + 1));
            if (k == WS + 1) begin
                check("rdata_ack", 32'(rdata), 32'(ref_rdata));
                check("err_ack", 32'(err), 32'(exp_err));
            end else begin
                check("rdata_hold", 32'(rdata), 32'(prev_rdata));
            end
        end
        @(posedge clk);
        @(negedge clk);
        ref_count = ref_count + 16'd1;
        check("busy_end", 32'(busy), 32'(0));
        check("ack_end", 32'(ack), 32'(0));
        check("err_end", 32'(err), 32'(0));
        check("count", 32'(access_count), 32'(ref_count));
        $display("txn %s addr=%h data=%h rdata=%h err=%0d count=%0d",
                 tw ? "WR" : "RD", ta, td, rdata, exp_err, access_count);
    endtask

    initial begin
        // Reset held with a pending request.
        req = 1'b1; w = 1'b1; addr = 16'd5; wdata = 16'h1234;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_ack", 32'(ack), 32'(0));
            check("rst_busy", 32'(busy), 32'(0));
            check("rst_rdata", 32'(rdata), 32'(0));
            check("rst_count", 32'(access_count), 32'(0));
            check("rst_err", 32'(err), 32'(0));
        end
        req = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'(0));

        for (int i = 0; i < DEPTH; i++) txn(1'b1, 16'(i), 16'($urandom), 1'b0);

        txn(1'b1, 16'd5, 16'h1234, 1'b0);
        txn(1'b0, 16'd5, 16'h0000, 1'b0);
        check("rd_after_wr", 32'(rdata), 32'h1234);

        txn(1'b1, 16'd40, 16'hBEEF, 1'b0);
        txn(1'b0, 16'd8, 16'h0000, 1'b0);
        txn(1'b0, 16'd40, 16'h0000, 1'b0);
        txn(1'b1, 16'd37, 16'hBEEF, 1'b0);
        txn(1'b0, 16'd5, 16'h0000, 1'b0);

        // Back-to-back reads with req held high throughout.
        for (int i = 0; i < 3; i++) txn(1'b0, 16'(i + 10), 16'h0000, 1'b1);
        req = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("idle_ack", 32'(ack), 32'(0));
            check("idle_busy2", 32'(busy), 32'(0));
        end

        for (int i = 0; i < 60; i++) begin
            txn(1'($urandom), 16'($urandom_range(0, 63)), 16'($urandom), 1'($urandom));
        end
        req = 1'b0;
        @(negedge clk);

        // Reset during WAIT must abandon the write.
        txn(1'b1, 16'd2, 16'h0001, 1'b0);
        req = 1'b1; w = 1'b1; addr = 16'd2; wdata = 16'hAAAA;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        check("mid_busy", 32'(busy), 32'(1));
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'(0));
        check("mid_rst_count", 32'(access_count), 32'(0));
        check("mid_rst_rdata", 32'(rdata), 32'(0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mid_rst_ack", 32'(ack), 32'(0));
        end
        rst_n = 1'b1;
        ref_count = '0;
        ref_rdata = '0;
        @(negedge clk);
        txn(1'b0, 16'd2, 16'h0000, 1'b0);
        check("mid_rst_data", 32'(rdata), 32'h0001);

        // Counter wrap from a preloaded 0xFFFF.
        force dut.count_reg = 16'hFFFF;
        #1;
        release dut.count_reg;
        ref_count = 16'hFFFF;
        @(negedge clk);
        txn(1'b0, 16'd3, 16'h0000, 1'b0);
        check("wrap", 32'(access_count), 32'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
